output_display: RTL and testbench
=================================

OUTPUT_DISPLAY -- requirements
Module: output_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clk cycles per displayed digit; 1 kHz digit rate at 100 MHz.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: bus  input  8  main bus value; read only, never driven.
REQ-005 Port: load  input  1  output-register load enable, level.
REQ-006 Port: step  input  1  one-clk-cycle pulse marking a computer clock edge.
REQ-007 Port: signed_mode  input  1  1 = display two's complement, 0 = unsigned.
REQ-008 Port: value  output  8  captured output-register contents.
REQ-009 Port: busy  output  1  binary-to-BCD conversion in progress.
REQ-010 Port: seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-011 Port: sel  output  4  digit select, one-hot active-low; sel[0] = rightmost digit.

Function
REQ-012 Capture: the block shall load bus into value in any cycle N with load=1 and step=1; value shall change at edge N+1; in that cycle the block shall also latch signed_mode into an internal mode bit.
REQ-013 load=1 with step=0, or step=1 with load=0, shall leave value unchanged.
REQ-014 Magnitude: with latched mode=1 and value[7]=1, magnitude = 256-value, 9 bits wide; 0x80 gives 128; in all other cases magnitude = value.
REQ-015 FSM states: IDLE and CONV. A capture moves the FSM to CONV and sets the iteration count to 0. CONV runs exactly 8 shift-add-3 (double-dabble) iterations, one per clk, then returns to IDLE.
REQ-016 busy shall be 1 for cycles N+1 through N+8 and 0 otherwise.
REQ-017 The displayed digit registers (hundreds, tens, units, sign) shall update only at the edge that leaves CONV. They hold old contents during conversion, so the display never shows partial BCD.
REQ-018 A capture during CONV shall update value, abort the current conversion and restart it from iteration 0; busy stays 1 continuously. Only the last capture is displayed.
REQ-019 Digit map: digit0 = units, always shown; digit1 = tens, blank if hundreds=0 and tens=0; digit2 = hundreds, blank if 0.
REQ-020 digit3 shall show '-' when latched mode=1 and value[7]=1, and blank otherwise.
REQ-021 Glyph patterns, active-high before inversion: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F, '-'=0x40, blank=0x00.
REQ-022 seg shall equal the bitwise inverse of the glyph. dp shall always be off (seg[7]=1).
REQ-023 Scan prescaler: the prescaler shall count 0..REFRESH_DIV-1 and then wrap. On wrap, the digit index shall advance 0→1→2→3→0.
REQ-024 sel = ~(1<<index). seg and sel shall be registered and change on the same edge, so no mismatched digit/segment cycle appears.
REQ-025 Scanning shall continue unaffected by captures and conversions.
REQ-026 A change of signed_mode without a capture shall not alter the display.

Reset
REQ-027 While rst=1 at an edge, the block shall set: value=0x00, busy=0, FSM=IDLE, mode=0, digits = units 0 with hundreds, tens and sign blank, prescaler=0, index=0, sel=4'b1110, seg=0xC0.
REQ-028 rst shall take priority over a simultaneous capture; the capture is discarded.
REQ-029 rst during CONV shall abort the conversion and apply the REQ-027 state at the next edge.
REQ-030 After rst deasserts, the display shall show "0" with no conversion run.

Verification
REQ-031 Reset then idle 4*REFRESH_DIV cycles (REFRESH_DIV=4 in bench) -> sel cycles 1110,1101,1011,0111; seg=0xC0 on sel 1110 and 0xFF on the others.
REQ-032 bus=0xFF, load=1, step pulse, signed_mode=0 -> value=0xFF next edge; busy high exactly 8 cycles; digits "255" with digit3 blank.
REQ-033 bus=0x80, signed_mode=1, capture -> "-128"; then bus=0x05, signed_mode=1, capture -> digit3, digit2, digit1 blank, digit0 = 5 (seg=0x92).
REQ-034 Capture 0x07, then capture 0xC8 (signed_mode=0) 3 cycles later -> busy stays high through cycle 11 after the first capture; the display never shows 7 and ends at "200".
REQ-035 Capture 0x2A, then assert rst at CONV iteration 4 -> next edge: value=0x00, busy=0, display "0".
REQ-036 step pulse with load=0, bus=0x33 -> value, busy and the display are unchanged; toggling signed_mode alone -> the display is unchanged.

Source files
------------

// File: rtl/output_display.sv
// Output register with an 8-step binary-to-BCD converter and a multiplexed
// four-digit seven-segment display driver (active-low segments and selects).
module output_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bus,
    input  logic       load,
    input  logic       step,
    input  logic       signed_mode,
    output logic [7:0] value,
    output logic       busy,
    output logic [7:0] seg,
    output logic [3:0] sel
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      value_q, value_d;
    logic            mode_q, mode_d;
    logic [2:0]      iter_q, iter_d;
    logic [19:0]     dd_q, dd_d;
    logic [3:0]      hund_q, hund_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      units_q, units_d;
    logic            sign_q, sign_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      seg_q, seg_d;
    logic [3:0]      sel_q, sel_d;

    logic            capture;
    logic [7:0]      mag;
    logic [19:0]     dd_step;
    logic [6:0]      glyph;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] glyph_of(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    always_comb begin
        capture = load & step;
        // Two's complement magnitude never exceeds 128, so 8 bits hold it.
        mag     = (signed_mode && bus[7]) ? (~bus + 8'd1) : bus;
        // dd = {hundreds, tens, units, remaining binary}; one double-dabble step.
        dd_step = {add3(dd_q[19:16]), add3(dd_q[15:12]), add3(dd_q[11:8]), dd_q[7:0]} << 1;

        state_d = state_q;
        value_d = value_q;
        mode_d  = mode_q;
        iter_d  = iter_q;
        dd_d    = dd_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        units_d = units_q;
        sign_d  = sign_q;

        if (capture) begin
            value_d = bus;
            mode_d  = signed_mode;
            state_d = CONV;
            iter_d  = 3'd0;
            dd_d    = {12'd0, mag};
        end else if (state_q == CONV) begin
            dd_d   = dd_step;
            iter_d = iter_q + 3'd1;
            if (iter_q == 3'd7) begin
                state_d = IDLE;
                hund_d  = dd_step[19:16];
                tens_d  = dd_step[15:12];
                units_d = dd_step[11:8];
                sign_d  = mode_q & value_q[7];
            end
        end

        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + PW'(1);
            idx_d   = idx_q;
        end

        case (idx_q)
            2'd0:    glyph = glyph_of(units_q);
            2'd1:    glyph = (hund_q == 4'd0 && tens_q == 4'd0) ? 7'h00 : glyph_of(tens_q);
            2'd2:    glyph = (hund_q == 4'd0) ? 7'h00 : glyph_of(hund_q);
            default: glyph = sign_q ? 7'h40 : 7'h00;
        endcase
        // seg and sel both derive from idx_q so they always move together.
        seg_d = {1'b1, ~glyph};
        sel_d = ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            value_q <= 8'h00;
            mode_q  <= 1'b0;
            iter_q  <= 3'd0;
            dd_q    <= 20'd0;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            sign_q  <= 1'b0;
            presc_q <= '0;
            idx_q   <= 2'd0;
            seg_q   <= 8'hC0;
            sel_q   <= 4'b1110;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            mode_q  <= mode_d;
            iter_q  <= iter_d;
            dd_q    <= dd_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            sign_q  <= sign_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign value = value_q;
    assign busy  = (state_q == CONV);
    assign seg   = seg_q;
    assign sel   = sel_q;

endmodule

// File: tb/tb_output_display.sv
// Directed bench for output_display: reset, scan order, conversion timing,
// signed display, capture restart, reset abort and non-capture inputs.
module tb_output_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus = 8'h00;
    logic       load = 1'b0;
    logic       step = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] value;
    logic       busy;
    logic [7:0] seg;
    logic [3:0] sel;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    output_display #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .load(load), .step(step),
        .signed_mode(signed_mode), .value(value), .busy(busy), .seg(seg), .sel(sel)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Capture in the next cycle; returns at the sample point of the cycle after.
    task automatic capture(input logic [7:0] b, input logic sm);
        @(negedge clk);
        bus = b; load = 1'b1; step = 1'b1; signed_mode = sm;
        @(negedge clk);
        load = 1'b0; step = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    // Sample seg while the given digit is selected; x if it never appears.
    task automatic get_seg(input int idx, output logic [7:0] s);
        logic [3:0] want;
        want = ~(4'b0001 << idx);
        s = 8'hxx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sel === want) begin
                s = seg;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int busy_seen;
        rst = 1'b1; bus = 8'hAA; load = 1'b1; step = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (value !== 8'h00) begin bad++; $display("FAIL reset_value: got %h want 00", value); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (sel !== 4'b1110) begin bad++; $display("FAIL reset_sel: got %b want 1110", sel); end
        total++; if (seg !== 8'hC0) begin bad++; $display("FAIL reset_seg: got %h want c0", seg); end
        rst = 1'b0; load = 1'b0; step = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        total++; if (busy_seen !== 0) begin bad++; $display("FAIL post_reset_busy: got %0d busy cycles want 0", busy_seen); end
        total++; if (value !== 8'h00) begin bad++; $display("FAIL post_reset_value: got %h want 00", value); end
    endtask

    task automatic test_scan();
        logic [3:0] prev;
        int seg_err, seq_err, run_err, trans, run;
        prev = sel; seg_err = 0; seq_err = 0; run_err = 0; trans = 0; run = 1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (sel === 4'b1110) begin
                if (seg !== 8'hC0) seg_err++;
            end else if (seg !== 8'hFF) seg_err++;
            if (sel !== prev) begin
                if (sel !== {prev[2:0], prev[3]}) seq_err++;
                if (trans > 0 && run != 4) run_err++;
                trans++;
                run = 1;
                prev = sel;
            end else run++;
        end
        total++; if (seg_err !== 0) begin bad++; $display("FAIL scan_seg: got %0d wrong samples want 0", seg_err); end
        total++; if (seq_err !== 0) begin bad++; $display("FAIL scan_order: got %0d bad steps want 0", seq_err); end
        total++; if (run_err !== 0) begin bad++; $display("FAIL scan_period: got %0d bad holds want 0", run_err); end
        total++; if (!(trans >= 5)) begin bad++; $display("FAIL scan_advance: got %0d steps want >=5", trans); end
    endtask

    task automatic test_unsigned_255();
        int cnt;
        logic [7:0] s;
        capture(8'hFF, 1'b0);
        total++; if (value !== 8'hFF) begin bad++; $display("FAIL u255_value: got %h want ff", value); end
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            cnt++;
            @(negedge clk);
        end
        total++; if (cnt !== 8) begin bad++; $display("FAIL u255_busy_len: got %0d want 8", cnt); end
        get_seg(0, s); total++; if (s !== 8'h92) begin bad++; $display("FAIL u255_d0: got %h want 92", s); end
        get_seg(1, s); total++; if (s !== 8'h92) begin bad++; $display("FAIL u255_d1: got %h want 92", s); end
        get_seg(2, s); total++; if (s !== 8'hA4) begin bad++; $display("FAIL u255_d2: got %h want a4", s); end
        get_seg(3, s); total++; if (s !== 8'hFF) begin bad++; $display("FAIL u255_d3: got %h want ff", s); end
    endtask

    task automatic test_signed();
        logic [7:0] s;
        capture(8'h80, 1'b1);
        wait_idle();
        total++; if (value !== 8'h80) begin bad++; $display("FAIL s128_value: got %h want 80", value); end
        get_seg(3, s); total++; if (s !== 8'hBF) begin bad++; $display("FAIL s128_d3: got %h want bf", s); end
        get_seg(2, s); total++; if (s !== 8'hF9) begin bad++; $display("FAIL s128_d2: got %h want f9", s); end
        get_seg(1, s); total++; if (s !== 8'hA4) begin bad++; $display("FAIL s128_d1: got %h want a4", s); end
        get_seg(0, s); total++; if (s !== 8'h80) begin bad++; $display("FAIL s128_d0: got %h want 80", s); end
        capture(8'h05, 1'b1);
        wait_idle();
        get_seg(3, s); total++; if (s !== 8'hFF) begin bad++; $display("FAIL s5_d3: got %h want ff", s); end
        get_seg(2, s); total++; if (s !== 8'hFF) begin bad++; $display("FAIL s5_d2: got %h want ff", s); end
        get_seg(1, s); total++; if (s !== 8'hFF) begin bad++; $display("FAIL s5_d1: got %h want ff", s); end
        get_seg(0, s); total++; if (s !== 8'h92) begin bad++; $display("FAIL s5_d0: got %h want 92", s); end
    endtask

    task automatic test_back_to_back();
        int run, seven;
        logic done;
        logic [7:0] s;
        run = 0; seven = 0; done = 1'b0;
        @(negedge clk);
        bus = 8'h07; load = 1'b1; step = 1'b1; signed_mode = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (!done && busy === 1'b1) run++;
            else done = 1'b1;
            if (sel === 4'b1110 && seg === 8'hF8) seven++;
            if (cyc == 3) begin
                bus = 8'hC8; load = 1'b1; step = 1'b1;
            end else begin
                load = 1'b0; step = 1'b0;
            end
        end
        total++; if (run !== 11) begin bad++; $display("FAIL b2b_busy_len: got %0d want 11", run); end
        total++; if (seven !== 0) begin bad++; $display("FAIL b2b_no_seven: got %0d samples want 0", seven); end
        total++; if (value !== 8'hC8) begin bad++; $display("FAIL b2b_value: got %h want c8", value); end
        get_seg(0, s); total++; if (s !== 8'hC0) begin bad++; $display("FAIL b2b_d0: got %h want c0", s); end
        get_seg(1, s); total++; if (s !== 8'hC0) begin bad++; $display("FAIL b2b_d1: got %h want c0", s); end
        get_seg(2, s); total++; if (s !== 8'hA4) begin bad++; $display("FAIL b2b_d2: got %h want a4", s); end
        get_seg(3, s); total++; if (s !== 8'hFF) begin bad++; $display("FAIL b2b_d3: got %h want ff", s); end
    endtask

    task automatic test_reset_mid_conv();
        logic [7:0] s;
        capture(8'h2A, 1'b0);
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (value !== 8'h00) begin bad++; $display("FAIL rmid_value: got %h want 00", value); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        total++; if (seg !== 8'hC0 || sel !== 4'b1110) begin bad++; $display("FAIL rmid_seg_sel: got %h/%b want c0/1110", seg, sel); end
        get_seg(0, s); total++; if (s !== 8'hC0) begin bad++; $display("FAIL rmid_d0: got %h want c0", s); end
        get_seg(1, s); total++; if (s !== 8'hFF) begin bad++; $display("FAIL rmid_d1: got %h want ff", s); end
        get_seg(2, s); total++; if (s !== 8'hFF) begin bad++; $display("FAIL rmid_d2: got %h want ff", s); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_no_capture();
        logic [7:0] s;
        capture(8'hFF, 1'b0);
        wait_idle();
        @(negedge clk);
        bus = 8'h33; step = 1'b1; load = 1'b0;
        @(negedge clk);
        step = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        total++; if (value !== 8'hFF) begin bad++; $display("FAIL nocap_value: got %h want ff", value); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nocap_busy: got %b want 0", busy); end
        signed_mode = 1'b1;
        get_seg(3, s); total++; if (s !== 8'hFF) begin bad++; $display("FAIL mode_d3: got %h want ff", s); end
        get_seg(2, s); total++; if (s !== 8'hA4) begin bad++; $display("FAIL mode_d2: got %h want a4", s); end
        get_seg(0, s); total++; if (s !== 8'h92) begin bad++; $display("FAIL mode_d0: got %h want 92", s); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mode_busy: got %b want 0", busy); end
        signed_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_unsigned_255();
        test_signed();
        test_back_to_back();
        test_reset_mid_conv();
        test_no_capture();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
